result_fwd_writeback: RTL and testbench

- Sits directly downstream of the execution units, including the Byte unit.
- Collects their 139-bit result packets into a 7-stage in-flight result shift register.
- Serves operand forwarding lookups for three source addresses from the in-flight results.
- Retires the stage-7 entry to the register-file write port.

---
 rtl/spu_result_pkg.sv | 54 +++++
 rtl/result_fwd_writeback_if.sv | 44 ++++
 rtl/fwd_match.sv | 32 +++
 rtl/result_fwd_writeback.sv | 122 ++++++++++++
 tb/tb_result_fwd_writeback.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_result_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spu_result_pkg
//  Description : Shared widths, packet field offsets and record types for the
//                result forwarding / writeback block.
//  Revision    : 1.0 - initial release
// ============================================================================
package spu_result_pkg;

   localparam int PKT_W  = 139;
   localparam int DATA_W = 128;
   localparam int ADDR_W = 7;
   localparam int LAT_W  = 3;

   // Bit offsets of the fields inside one unit packet
   localparam int DATA_LSB = 0;
   localparam int LAT_LSB  = 128;
   localparam int WEN_BIT  = 131;
   localparam int RT_LSB   = 132;

   typedef struct packed {
      logic [ADDR_W-1:0] rt;
      logic              wen;
      logic [LAT_W-1:0]  lat;
      logic [DATA_W-1:0] data;
   } result_pkt_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              wen;
      logic [ADDR_W-1:0] rt;
   } stage_entry_t;

   // Extract the fields of a raw packet using the documented offsets
   function automatic result_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
      result_pkt_t p;
      p.data = raw[DATA_LSB +: DATA_W];
      p.lat  = raw[LAT_LSB  +: LAT_W];
      p.wen  = raw[WEN_BIT];
      p.rt   = raw[RT_LSB   +: ADDR_W];
      return p;
   endfunction

   // In-flight record for a packet; latency is consumed at insertion time
   function automatic stage_entry_t pkt_to_entry(input result_pkt_t p);
      stage_entry_t e;
      e.data = p.data;
      e.wen  = p.wen;
      e.rt   = p.rt;
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/result_fwd_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : result_fwd_writeback_if
//  Description : Bus bundle for the result forwarding / writeback block:
//                unit packets and flush in, three lookups and the
//                register-file write port out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface result_fwd_writeback_if
   import spu_result_pkg::*;
#(
   parameter int NUM_UNITS = 4
);
   logic [NUM_UNITS*PKT_W-1:0] in_pkt;
   logic                       flush;
   logic [ADDR_W-1:0]          addr_ra;
   logic [ADDR_W-1:0]          addr_rb;
   logic [ADDR_W-1:0]          addr_rc;
   logic                       fwd_ra_hit;
   logic                       fwd_rb_hit;
   logic                       fwd_rc_hit;
   logic [DATA_W-1:0]          fwd_ra_data;
   logic [DATA_W-1:0]          fwd_rb_data;
   logic [DATA_W-1:0]          fwd_rc_data;
   logic                       rf_we;
   logic [ADDR_W-1:0]          rf_waddr;
   logic [DATA_W-1:0]          rf_wdata;
   logic                       collision_err;

   modport master (
      output in_pkt, flush, addr_ra, addr_rb, addr_rc,
      input  fwd_ra_hit, fwd_rb_hit, fwd_rc_hit,
             fwd_ra_data, fwd_rb_data, fwd_rc_data,
             rf_we, rf_waddr, rf_wdata, collision_err
   );

   modport slave (
      input  in_pkt, flush, addr_ra, addr_rb, addr_rc,
      output fwd_ra_hit, fwd_rb_hit, fwd_rc_hit,
             fwd_ra_data, fwd_rb_data, fwd_rc_data,
             rf_we, rf_waddr, rf_wdata, collision_err
   );
endinterface
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match
//  Description : Priority match of one source address against the candidate
//                vector; index 0 is the youngest and wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
   import spu_result_pkg::*;
#(
   parameter int NUM_CAND = 8
)(
   input  logic [ADDR_W-1:0]                addr,
   input  stage_entry_t [NUM_CAND-1:0]      cands,
   output logic                             hit,
   output logic [DATA_W-1:0]                data
);

   // Scan oldest to youngest so the youngest match overwrites older ones
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = NUM_CAND-1; i >= 0; i--) begin
         if (cands[i].wen && (cands[i].rt == addr)) begin
            hit  = 1'b1;
            data = cands[i].data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/result_fwd_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : result_fwd_writeback
//  Description : In-flight result shift register fed by the execution units.
//                Packets enter at the stage equal to their latency, shift one
//                stage per cycle, retire from the last stage into the
//                register-file write port and are forwardable meanwhile.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_fwd_writeback
   import spu_result_pkg::*;
#(
   parameter int NUM_UNITS   = 4,
   parameter int NUM_STAGES  = 7,
   parameter int FLUSH_DEPTH = 3
)(
   input  logic                    clk,
   input  logic                    reset,
   result_fwd_writeback_if.slave   bus
);

   localparam int NUM_CAND = NUM_STAGES + 1;

   stage_entry_t                 r_stage [1:NUM_STAGES];
   stage_entry_t                 w_next  [1:NUM_STAGES];
   stage_entry_t                 r_rf;
   logic                         r_coll;
   logic                         w_coll;
   logic [NUM_STAGES:1]          w_taken;
   result_pkt_t                  w_pkt;
   stage_entry_t [NUM_CAND-1:0]  w_cands;

   // Next stage contents: shift, insert by latency (lowest unit first), flush
   always_comb begin
      w_next[1] = '0;
      for (int k = 2; k <= NUM_STAGES; k++) begin
         w_next[k] = r_stage[k-1];
      end
      w_coll  = 1'b0;
      w_taken = '0;
      w_pkt   = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         w_pkt = unpack_pkt(bus.in_pkt[u*PKT_W +: PKT_W]);
         if (w_pkt.wen) begin
            if (w_pkt.lat == '0) begin
               // zero latency has no stage to land in
               w_coll = 1'b1;
            end else if (int'(w_pkt.lat) <= NUM_STAGES) begin
               if (w_taken[w_pkt.lat]) begin
                  // a lower-numbered unit already claimed this stage
                  w_coll = 1'b1;
               end else begin
                  if (w_next[w_pkt.lat].wen) begin
                     w_coll = 1'b1;
                  end
                  w_next[w_pkt.lat]  = pkt_to_entry(w_pkt);
                  w_taken[w_pkt.lat] = 1'b1;
               end
            end
         end
      end
      // flush kills the youngest stages, including fresh insertions
      if (bus.flush) begin
         for (int k = 1; k <= FLUSH_DEPTH; k++) begin
            w_next[k] = '0;
         end
      end
   end

   // Stage registers, retire register and sticky collision flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            r_stage[k] <= '0;
         end
         r_rf   <= '0;
         r_coll <= 1'b0;
      end else begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            r_stage[k] <= w_next[k];
         end
         r_rf   <= r_stage[NUM_STAGES];
         r_coll <= r_coll | w_coll;
      end
   end

   // Candidate vector, youngest first, retire register last
   always_comb begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
         w_cands[k-1] = r_stage[k];
      end
      w_cands[NUM_STAGES] = r_rf;
   end

   fwd_match #(.NUM_CAND(NUM_CAND)) u_match_ra (
      .addr  (bus.addr_ra),
      .cands (w_cands),
      .hit   (bus.fwd_ra_hit),
      .data  (bus.fwd_ra_data)
   );

   fwd_match #(.NUM_CAND(NUM_CAND)) u_match_rb (
      .addr  (bus.addr_rb),
      .cands (w_cands),
      .hit   (bus.fwd_rb_hit),
      .data  (bus.fwd_rb_data)
   );

   fwd_match #(.NUM_CAND(NUM_CAND)) u_match_rc (
      .addr  (bus.addr_rc),
      .cands (w_cands),
      .hit   (bus.fwd_rc_hit),
      .data  (bus.fwd_rc_data)
   );

   assign bus.rf_we         = r_rf.wen;
   assign bus.rf_waddr      = r_rf.rt;
   assign bus.rf_wdata      = r_rf.data;
   assign bus.collision_err = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_result_fwd_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_fwd_writeback
//  Description : Directed scenarios plus randomized traffic against a
//                list-of-packets reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_result_fwd_writeback;

   localparam int NU = 4;
   localparam int PW = 139;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   result_fwd_writeback_if #(.NUM_UNITS(NU)) bus ();

   result_fwd_writeback #(
      .NUM_UNITS   (NU),
      .NUM_STAGES  (7),
      .FLUSH_DEPTH (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each live packet is a record with its current position: 1..7 = stage,
   // 8 = sitting on the register-file write port.
   typedef struct {
      logic [127:0] data;
      logic [6:0]   rt;
      int           pos;
   } rec_t;

   rec_t m_q[$];
   bit   m_coll;

   function automatic logic [138:0] mk_pkt(input logic [127:0] d, input int lat,
                                           input bit wen, input int rt);
      logic [138:0] p;
      p[127:0]   = d;
      p[130:128] = lat[2:0];
      p[131]     = wen;
      p[138:132] = rt[6:0];
      return p;
   endfunction

   function automatic logic [NU*PW-1:0] place(input int u, input logic [138:0] p);
      logic [NU*PW-1:0] v;
      v = '0;
      v[u*PW +: PW] = p;
      return v;
   endfunction

   task automatic m_lookup(input logic [6:0] a, output bit hit, output logic [127:0] d);
      int best;
      best = 100;
      hit  = 1'b0;
      d    = '0;
      foreach (m_q[i]) begin
         if (m_q[i].rt == a && m_q[i].pos < best) begin
            best = m_q[i].pos;
            hit  = 1'b1;
            d    = m_q[i].data;
         end
      end
   endtask

   task automatic m_step(input logic [NU*PW-1:0] pk, input bit fl);
      rec_t nq[$];
      rec_t tq[$];
      int   newl[$];
      foreach (m_q[i]) begin
         if (m_q[i].pos < 8) begin
            rec_t r;
            r = m_q[i];
            r.pos++;
            nq.push_back(r);
         end
      end
      for (int u = 0; u < NU; u++) begin
         logic [138:0] p;
         int  lat;
         bit  dup;
         rec_t r;
         p   = pk[u*PW +: PW];
         lat = int'(p[130:128]);
         dup = 1'b0;
         if (p[131]) begin
            if (lat == 0) begin
               m_coll = 1'b1;
            end else begin
               foreach (newl[j]) if (newl[j] == lat) dup = 1'b1;
               if (dup) begin
                  m_coll = 1'b1;
               end else begin
                  tq.delete();
                  foreach (nq[j]) begin
                     if (nq[j].pos == lat) m_coll = 1'b1;
                     else tq.push_back(nq[j]);
                  end
                  nq = tq;
                  r.data = p[127:0];
                  r.rt   = p[138:132];
                  r.pos  = lat;
                  nq.push_back(r);
                  newl.push_back(lat);
               end
            end
         end
      end
      if (fl) begin
         tq.delete();
         foreach (nq[j]) if (nq[j].pos > 3) tq.push_back(nq[j]);
         nq = tq;
      end
      m_q = nq;
   endtask

   task automatic check_all();
      bit           h;
      logic [127:0] d;
      logic         e_we;
      logic [6:0]   e_a;
      logic [127:0] e_d;
      m_lookup(bus.addr_ra, h, d);
      check_eq("ra_hit",  128'(bus.fwd_ra_hit), 128'(h));
      check_eq("ra_data", bus.fwd_ra_data, d);
      m_lookup(bus.addr_rb, h, d);
      check_eq("rb_hit",  128'(bus.fwd_rb_hit), 128'(h));
      check_eq("rb_data", bus.fwd_rb_data, d);
      m_lookup(bus.addr_rc, h, d);
      check_eq("rc_hit",  128'(bus.fwd_rc_hit), 128'(h));
      check_eq("rc_data", bus.fwd_rc_data, d);
      e_we = 1'b0;
      e_a  = '0;
      e_d  = '0;
      foreach (m_q[i]) begin
         if (m_q[i].pos == 8) begin
            e_we = 1'b1;
            e_a  = m_q[i].rt;
            e_d  = m_q[i].data;
         end
      end
      check_eq("rf_we",    128'(bus.rf_we),         128'(e_we));
      check_eq("rf_waddr", 128'(bus.rf_waddr),      128'(e_a));
      check_eq("rf_wdata", bus.rf_wdata,            e_d);
      check_eq("coll_err", 128'(bus.collision_err), 128'(m_coll));
   endtask

   // Called at a negedge: drive, check current outputs, advance model, clock
   task automatic do_cycle(input logic [NU*PW-1:0] pk, input bit fl,
                           input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc);
      bus.in_pkt  = pk;
      bus.flush   = fl;
      bus.addr_ra = ra;
      bus.addr_rb = rb;
      bus.addr_rc = rc;
      #1;
      check_all();
      m_step(pk, fl);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      repeat (9) do_cycle('0, 1'b0, 7'd0, 7'd0, 7'd0);
   endtask

   // Assert reset between edges, check immediately, release on a negedge
   task automatic async_reset();
      #2;
      reset = 1'b0;
      m_q.delete();
      m_coll = 1'b0;
      #1;
      check_all();
      check_eq("rst_rf_we", 128'(bus.rf_we), 128'(0));
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [NU*PW-1:0] rpk;

   initial begin
      bus.in_pkt  = '0;
      bus.flush   = 1'b0;
      bus.addr_ra = '0;
      bus.addr_rb = '0;
      bus.addr_rc = '0;
      m_coll      = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_all();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // single packet, L=4, rt=5
      do_cycle(place(0, mk_pkt({16{8'hA5}}, 4, 1'b1, 5)), 1'b0, 7'd5, 7'd0, 7'd0);
      for (int c = 1; c <= 6; c++) begin
         check_eq("single_hit",  128'(bus.fwd_ra_hit), 128'(c <= 5));
         check_eq("single_rfwe", 128'(bus.rf_we),      128'(c == 5));
         do_cycle('0, 1'b0, 7'd5, 7'd0, 7'd0);
      end
      drain();

      // youngest wins: rt=9 data=1 L=6, then rt=9 data=2 L=2
      do_cycle(place(0, mk_pkt(128'd1, 6, 1'b1, 9)), 1'b0, 7'd0, 7'd9, 7'd0);
      do_cycle(place(0, mk_pkt(128'd2, 2, 1'b1, 9)), 1'b0, 7'd0, 7'd9, 7'd0);
      check_eq("young_data", bus.fwd_rb_data, 128'd2);
      do_cycle('0, 1'b0, 7'd0, 7'd9, 7'd0);
      check_eq("young_data2", bus.fwd_rb_data, 128'd2);
      drain();

      // same-L collision between units 1 and 2
      do_cycle(place(1, mk_pkt(128'h11, 3, 1'b1, 11)) | place(2, mk_pkt(128'h12, 3, 1'b1, 12)),
               1'b0, 7'd11, 7'd12, 7'd0);
      check_eq("coll_set", 128'(bus.collision_err), 128'(1));
      check_eq("coll_win", 128'(bus.fwd_ra_hit), 128'(1));
      drain();
      check_eq("coll_sticky", 128'(bus.collision_err), 128'(1));

      // flush: L=2 rt=3 removed, L=5 rt=4 survives
      do_cycle(place(0, mk_pkt(128'h33, 2, 1'b1, 3)) | place(1, mk_pkt(128'h44, 5, 1'b1, 4)),
               1'b0, 7'd3, 7'd4, 7'd0);
      do_cycle('0, 1'b1, 7'd3, 7'd4, 7'd0);
      check_eq("flush_gone", 128'(bus.fwd_ra_hit), 128'(0));
      check_eq("flush_keep", 128'(bus.fwd_rb_hit), 128'(1));
      drain();

      // three-port lookup, only rt=6 in flight
      do_cycle(place(0, mk_pkt(128'h66, 5, 1'b1, 6)), 1'b0, 7'd5, 7'd6, 7'd7);
      check_eq("tp_ra_hit",  128'(bus.fwd_ra_hit), 128'(0));
      check_eq("tp_rb_hit",  128'(bus.fwd_rb_hit), 128'(1));
      check_eq("tp_rc_hit",  128'(bus.fwd_rc_hit), 128'(0));
      check_eq("tp_ra_data", bus.fwd_ra_data, 128'(0));
      check_eq("tp_rc_data", bus.fwd_rc_data, 128'(0));

      // async reset mid-flight
      do_cycle(place(3, mk_pkt(128'h77, 1, 1'b1, 7)), 1'b0, 7'd6, 7'd7, 7'd0);
      async_reset();
      repeat (10) do_cycle('0, 1'b0, 7'd6, 7'd7, 7'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rpk = '0;
         for (int u = 0; u < NU; u++) begin
            int  lat;
            bit  wen;
            wen = ($urandom_range(0, 2) != 0);
            lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 7));
            rpk[u*PW +: PW] = mk_pkt({$urandom, $urandom, $urandom, $urandom}, lat, wen,
                                     int'($urandom_range(0, 15)));
         end
         do_cycle(rpk, ($urandom_range(0, 9) == 0),
                  7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                  7'($urandom_range(0, 15)));
         if (n == 200) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
